// File: rtl/lsu_rmw_if.sv
// Bus bundle for the load/store unit: the core request channel, the
// completion channel, and the single-ported data memory port.
interface lsu_rmw_if #(
  parameter int AW = 32
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_misalign;

  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Core plus memory side: issues requests and returns memory read data
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign,
    input  mem_wr_en, mem_addr, mem_wdata
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign,
    output mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit for a 32-bit little-endian word memory. Sub-word stores
// are done as read-modify-write: read the word, patch the addressed lane,
// write the whole word back. Misaligned or illegal-size accesses are
// rejected without touching memory.
module lsu_rmw #(
  parameter int AW = 32
) (
  input logic     clk,
  input logic     rst,
  lsu_rmw_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic [31:0]   word_q;

  logic          accept;
  logic          req_mis;
  logic          lat_mis;
  logic [AW-1:0] word_idx;
  logic [31:0]   load_data;
  logic [31:0]   merge_data;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 11 is never legal
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lsb[0];
      2'b10:   mis = (lsb != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  assign accept   = bus.req_valid && (state == IDLE);
  assign req_mis  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign lat_mis  = is_misaligned(size_q, addr_q[1:0]);
  assign word_idx = {2'b00, addr_q[AW-1:2]};

  // State register; reset drops any in-flight access on the spot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request fields latched on accept, memory word captured at the end of RD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD) begin
        word_q <= bus.mem_rdata;
      end
    end
  end

  // Next state: word stores skip the read, rejected accesses skip memory
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_mis) begin
            state_next = RESP;
          end else if (bus.req_we && (bus.req_size == 2'b10)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load lane selection and sign/zero extension from the captured word
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b    = 8'h00;
    lane_h    = 16'h0000;
    load_data = word_q;
    case (addr_q[1:0])
      2'b00:   lane_b = word_q[7:0];
      2'b01:   lane_b = word_q[15:8];
      2'b10:   lane_b = word_q[23:16];
      default: lane_b = word_q[31:24];
    endcase
    lane_h = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_data = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = word_q;
    endcase
  end

  // Store word: addressed lane patched into the captured word, or the full store data
  always_comb begin
    merge_data = word_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merge_data[7:0]   = wdata_q[7:0];
          2'b01:   merge_data[15:8]  = wdata_q[7:0];
          2'b10:   merge_data[23:16] = wdata_q[7:0];
          default: merge_data[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          merge_data[31:16] = wdata_q[15:0];
        end else begin
          merge_data[15:0] = wdata_q[15:0];
        end
      end
      default: merge_data = wdata_q;
    endcase
  end

  // Outputs decoded from state; everything idles at zero outside its state
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = 32'h0;
    bus.rsp_misalign = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = 32'h0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      RD:   bus.mem_addr  = word_idx;
      WR: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = word_idx;
        bus.mem_wdata = merge_data;
      end
      RESP: begin
        bus.rsp_valid    = 1'b1;
        bus.rsp_misalign = lat_mis;
        bus.rsp_rdata    = (lat_mis || we_q) ? 32'h0 : load_data;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: requests push their expected response,
// a monitor pops and compares each rsp_valid pulse, and a small word
// memory model answers reads and absorbs writes.
module tb_lsu_rmw;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lsu_rmw_if #(.AW(32)) bus ();

  lsu_rmw #(.AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          writes = 0;
  int          rd_cycles = 0;
  logic [31:0] last_rd_addr = 32'h0;

  logic [31:0] mem [0:15] = '{32'h0, 32'h11223344, 32'h0, 32'h0,
                              32'h8899AABB, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};

  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model write port and write-pulse counter
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      writes <= writes + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: response scoreboard plus idle-value checks, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
        checkOutput("rsp_misalign", {31'h0, bus.rsp_misalign}, {31'h0, e.mis});
        checkOutput("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end else begin
      checkOutput("idle_rsp", {bus.rsp_rdata[30:0], bus.rsp_misalign} | {31'h0, bus.rsp_rdata[31]}, 32'h0);
    end
    if (bus.req_ready || bus.rsp_valid) begin
      checkOutput("idle_mem", {31'h0, bus.mem_wr_en} | bus.mem_addr | bus.mem_wdata, 32'h0);
    end
    if (rst && !bus.req_ready && !bus.rsp_valid && !bus.mem_wr_en) begin
      rd_cycles++;
      last_rd_addr = bus.mem_addr;
    end
  end

  // Present one request and return the cycle stamp of its accept edge
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expect_rsp,
                               input logic [31:0] exp_rdata, input logic exp_mis,
                               input int exp_lat, output int acc);
    int waited;
    exp_t e;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_timeout", {31'h0, bus.req_ready}, 32'd1);
    if (!bus.req_ready) begin
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.mis   = exp_mis;
      e.lat   = exp_lat;
      e.acc   = acc;
      sb.push_back(e);
    end
  endtask

  // Drop the request and wait, bounded, for the scoreboard to drain
  task automatic waitIdle();
    int waited;
    bus.req_valid = 1'b0;
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'h0, bus.req_ready}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    checkOutput({tag, "_rsp_mis"}, {31'h0, bus.rsp_misalign}, 32'd0);
    checkOutput({tag, "_mem_wr_en"}, {31'h0, bus.mem_wr_en}, 32'd0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  // Hard stop if the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int acc;
    int acc2;
    int w0;
    int r0;
    int rel;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b1;

    // Loads of word 4 = 0x8899AABB across sizes, lanes and extension
    r0 = rd_cycles;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h8899AABB, 1'b0, 2, acc);
    waitIdle();
    checkOutput("ld_word_mem_addr", last_rd_addr, 32'd4);
    checkOutput("ld_word_rd_cycles", rd_cycles - r0, 32'd1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF88, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000088, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFFFFBB, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 32'h000000AA, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFFAABB, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 32'h00008899, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, 1'b1, 32'h00000044, 1'b0, 2, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 1'b1, 32'h00001122, 1'b0, 2, acc);
    waitIdle();

    // Sub-word stores into word 4: read once, write once, other lanes kept
    w0 = writes;
    r0 = rd_cycles;
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 1'b1, 32'h0, 1'b0, 3, acc);
    waitIdle();
    checkOutput("st_half_writes", writes - w0, 32'd1);
    checkOutput("st_half_reads", rd_cycles - r0, 32'd1);
    checkOutput("st_half_mem", mem[4], 32'h1234AABB);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF77, 1'b1, 32'h0, 1'b0, 3, acc);
    waitIdle();
    checkOutput("st_byte_mem", mem[4], 32'h123477BB);

    // Rejected accesses: no read, no write, one-cycle response
    w0 = writes;
    r0 = rd_cycles;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc);
    waitIdle();
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, 1'b1, 32'h0, 1'b1, 1, acc);
    waitIdle();
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1, acc);
    waitIdle();
    checkOutput("mis_writes", writes - w0, 32'd0);
    checkOutput("mis_reads", rd_cycles - r0, 32'd0);
    checkOutput("mis_mem", mem[4], 32'h123477BB);

    // Reset in the middle of a byte store to word 1
    w0 = writes;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h05, 32'h000000EE, 1'b0, 32'h0, 1'b0, 0, acc);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rel = cyc;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b1, 32'h11223344, 1'b0, 2, acc);
    checkOutput("first_accept_after_reset", acc - rel, 32'd1);
    waitIdle();
    checkOutput("abort_writes", writes - w0, 32'd0);
    checkOutput("abort_mem", mem[1], 32'h11223344);

    // Back-to-back word store then load with req_valid held high
    w0 = writes;
    r0 = rd_cycles;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2, acc);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 2, acc2);
    waitIdle();
    checkOutput("b2b_gap", acc2 - acc, 32'd3);
    checkOutput("b2b_writes", writes - w0, 32'd1);
    checkOutput("b2b_reads", rd_cycles - r0, 32'd1);
    checkOutput("b2b_mem", mem[8], 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
